// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared opcodes, predecode classes, fetch state and packet types
package fetch_pkg;

  localparam int FETCH_XLEN = 32;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [4:0] LINK_RA = 5'd1;
  localparam logic [4:0] LINK_T0 = 5'd5;

  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_CALL_J,
    CLS_JAL_PLAIN,
    CLS_RET,
    CLS_CALL_R,
    CLS_JALR_OTHER,
    CLS_BR
  } pd_class_e;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic                  valid;
    logic [FETCH_XLEN-1:0] pc;
    logic [31:0]           inst;
    logic [FETCH_XLEN-1:0] npc;
    logic                  pred_taken;
  } if_packet_t;

  function automatic logic is_link(input logic [4:0] r);
    return (r == LINK_RA) || (r == LINK_T0);
  endfunction

  // A jalr that both writes and reads a link register is treated as a call (push only).
  function automatic pd_class_e predecode(input logic [6:0] opcode,
                                          input logic [4:0] rd,
                                          input logic [4:0] rs1);
    pd_class_e cls;
    cls = CLS_NONE;
    if (opcode == OPC_JAL) begin
      cls = is_link(rd) ? CLS_CALL_J : CLS_JAL_PLAIN;
    end else if (opcode == OPC_JALR) begin
      if (is_link(rd))                    cls = CLS_CALL_R;
      else if (rd == 5'd0 && is_link(rs1)) cls = CLS_RET;
      else                                cls = CLS_JALR_OTHER;
    end else if (opcode == OPC_BRANCH) begin
      cls = CLS_BR;
    end
    return cls;
  endfunction

endpackage

// File: rtl/fetch_btb.sv
// rtl/fetch_btb.sv - direct-mapped branch target buffer with one commit write port
module fetch_btb #(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 8,
  parameter int BTB_IDX_LEN = 3
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            lookup_hit,
  output logic [XLEN-1:0] lookup_target,
  input  logic            wr_en,
  input  logic [XLEN-1:0] wr_pc,
  input  logic [XLEN-1:0] wr_target
);

  localparam int TAG_LEN = XLEN - BTB_IDX_LEN - 2;

  logic [BTB_ENTRIES-1:0] valid;
  logic [TAG_LEN-1:0]     tags    [BTB_ENTRIES];
  logic [XLEN-1:0]        targets [BTB_ENTRIES];

  logic [BTB_IDX_LEN-1:0] rd_idx, wr_idx;
  logic [TAG_LEN-1:0]     rd_tag, wr_tag;

  assign rd_idx = lookup_pc[BTB_IDX_LEN+1:2];
  assign rd_tag = lookup_pc[XLEN-1:BTB_IDX_LEN+2];
  assign wr_idx = wr_pc[BTB_IDX_LEN+1:2];
  assign wr_tag = wr_pc[XLEN-1:BTB_IDX_LEN+2];

  // Byte offset bits never take part in indexing or tagging.
  logic unused_offset;
  assign unused_offset = ^{lookup_pc[1:0], wr_pc[1:0]};

  // Lookup reads storage directly, so a same-index write this cycle is not seen until next cycle.
  assign lookup_hit    = valid[rd_idx] && (tags[rd_idx] == rd_tag);
  assign lookup_target = targets[rd_idx];

  // Valid bits: cleared by reset, set on commit write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) valid <= '0;
    else if (wr_en) valid[wr_idx] <= 1'b1;
  end

  // Tag/target payload: unconditional overwrite of the indexed slot.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      tags[wr_idx]    <= wr_tag;
      targets[wr_idx] <= wr_target;
    end
  end

endmodule

// File: rtl/fetch_next_pc.sv
// rtl/fetch_next_pc.sv - fetch PC generator with RAS control and optional BTB (FETCH_BTB_EN)
import fetch_pkg::*;

module fetch_next_pc #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int              BTB_ENTRIES = 8,
  parameter int              BTB_IDX_LEN = 3
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [31:0]     if_inst,
  input  logic            if_inst_valid,
  input  logic            dispatch_stall,
  input  logic            commit_mis_pred,
  input  logic [XLEN-1:0] commit_target_PC,
  input  logic            commit_btb_wr_en,
  input  logic [XLEN-1:0] commit_btb_PC,
  input  logic [XLEN-1:0] commit_btb_target,
  input  logic            read_from_ras,
  input  logic [XLEN-1:0] jal_ret_addr,
  output logic [XLEN-1:0] fetch_PC,
  output logic            if_packet_valid,
  output logic [XLEN-1:0] if_packet_PC,
  output logic [31:0]     if_packet_inst,
  output logic [XLEN-1:0] if_packet_NPC,
  output logic            if_packet_pred_taken,
  output logic            ras_push_enable,
  output logic            ras_pop_enable,
  output logic [XLEN-1:0] jal_PC_plus_4
);

  fetch_state_e    state, next_state;
  if_packet_t      pkt;
  pd_class_e       cls;
  logic            accept, btb_hit, is_call, is_jal, btb_eligible;
  logic [XLEN-1:0] pc_plus_4, jal_target, npc, btb_target;

  assign cls       = predecode(if_inst[6:0], if_inst[11:7], if_inst[19:15]);
  assign pc_plus_4 = fetch_PC + XLEN'(4);
  assign jal_target = fetch_PC + {{(XLEN-20){if_inst[31]}}, if_inst[19:12],
                                  if_inst[20], if_inst[30:21], 1'b0};

  assign is_call      = (cls == CLS_CALL_J) || (cls == CLS_CALL_R);
  assign is_jal       = (cls == CLS_CALL_J) || (cls == CLS_JAL_PLAIN);
  // Every indirect-target class may use the BTB, including a ret that found the RAS empty.
  assign btb_eligible = (cls == CLS_CALL_R) || (cls == CLS_JALR_OTHER) ||
                        (cls == CLS_BR)     || (cls == CLS_RET);

  // Reset gating keeps the combinational RAS controls quiet while reset is held.
  assign accept = ~reset & if_inst_valid & ~dispatch_stall & ~commit_mis_pred & (state == RUN);

  assign ras_push_enable = accept & is_call;
  assign ras_pop_enable  = accept & (cls == CLS_RET) & read_from_ras;
  assign jal_PC_plus_4   = ras_push_enable ? pc_plus_4 : '0;

`ifdef FETCH_BTB_EN
  fetch_btb #(
    .XLEN        (XLEN),
    .BTB_ENTRIES (BTB_ENTRIES),
    .BTB_IDX_LEN (BTB_IDX_LEN)
  ) u_btb (
    .clock         (clock),
    .reset         (reset),
    .lookup_pc     (fetch_PC),
    .lookup_hit    (btb_hit),
    .lookup_target (btb_target),
    .wr_en         (commit_btb_wr_en),
    .wr_pc         (commit_btb_PC),
    .wr_target     (commit_btb_target)
  );
`else
  assign btb_hit    = 1'b0;
  assign btb_target = '0;
  logic unused_btb;
  assign unused_btb = ^{commit_btb_wr_en, commit_btb_PC, commit_btb_target};
`endif

  // Next-PC selection: RAS return, direct jump, BTB, then sequential.
  always_comb begin
    npc = pc_plus_4;
    if ((cls == CLS_RET) && read_from_ras) npc = jal_ret_addr;
    else if (is_jal)                       npc = jal_target;
    else if (btb_eligible && btb_hit)      npc = btb_target;
  end

  // Next state: any redirect inserts a bubble; FLUSH always returns to RUN.
  always_comb begin
    next_state = RUN;
    if (commit_mis_pred) next_state = FLUSH;
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= next_state;
  end

  // Fetch PC and packet register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_PC <= RESET_PC;
      pkt      <= '0;
    end else if (commit_mis_pred) begin
      fetch_PC  <= commit_target_PC;
      pkt.valid <= 1'b0;
    end else begin
      pkt.valid <= accept;
      if (accept) begin
        pkt.pc         <= fetch_PC;
        pkt.inst       <= if_inst;
        pkt.npc        <= npc;
        pkt.pred_taken <= (npc != pc_plus_4);
        fetch_PC       <= npc;
      end
    end
  end

  assign if_packet_valid      = pkt.valid;
  assign if_packet_PC         = pkt.pc;
  assign if_packet_inst       = pkt.inst;
  assign if_packet_NPC        = pkt.npc;
  assign if_packet_pred_taken = pkt.pred_taken;

endmodule

// File: tb/tb_fetch_next_pc.sv
// tb/tb_fetch_next_pc.sv - self-checking bench for fetch_next_pc against a behavioural model
module tb_fetch_next_pc;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] if_inst;
  logic        if_inst_valid, dispatch_stall, commit_mis_pred;
  logic [31:0] commit_target_PC;
  logic        commit_btb_wr_en;
  logic [31:0] commit_btb_PC, commit_btb_target;
  logic        read_from_ras;
  logic [31:0] jal_ret_addr;
  logic [31:0] fetch_PC, if_packet_PC, if_packet_inst, if_packet_NPC, jal_PC_plus_4;
  logic        if_packet_valid, if_packet_pred_taken, ras_push_enable, ras_pop_enable;

  fetch_next_pc dut (
    .clock(clock), .reset(reset), .if_inst(if_inst), .if_inst_valid(if_inst_valid),
    .dispatch_stall(dispatch_stall), .commit_mis_pred(commit_mis_pred),
    .commit_target_PC(commit_target_PC), .commit_btb_wr_en(commit_btb_wr_en),
    .commit_btb_PC(commit_btb_PC), .commit_btb_target(commit_btb_target),
    .read_from_ras(read_from_ras), .jal_ret_addr(jal_ret_addr), .fetch_PC(fetch_PC),
    .if_packet_valid(if_packet_valid), .if_packet_PC(if_packet_PC),
    .if_packet_inst(if_packet_inst), .if_packet_NPC(if_packet_NPC),
    .if_packet_pred_taken(if_packet_pred_taken), .ras_push_enable(ras_push_enable),
    .ras_pop_enable(ras_pop_enable), .jal_PC_plus_4(jal_PC_plus_4)
  );

  always #5 clock = ~clock;

`ifdef FETCH_BTB_EN
  localparam bit BTB_ON = 1'b1;
`else
  localparam bit BTB_ON = 1'b0;
`endif

  localparam logic [31:0] NOP      = 32'h00000013;
  localparam logic [31:0] CALL_J40 = 32'h040000EF;
  localparam logic [31:0] RET      = 32'h00008067;
  localparam logic [31:0] JALR_X6  = 32'h00030067;

  int compared = 0;
  int mismatched = 0;

  // Reference model state
  logic [31:0] m_pc;
  bit          m_flush;
  bit          m_valid, m_taken;
  logic [31:0] m_ppc, m_pinst, m_npc;
  bit          m_bv  [8];
  logic [31:0] m_bpc [8];
  logic [31:0] m_btg [8];
  logic        last_push;
  logic [31:0] last_pl4;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit link(input int r);
    return (r == 1) || (r == 5);
  endfunction

  task automatic idle();
    if_inst_valid = 1'b1; dispatch_stall = 1'b0; commit_mis_pred = 1'b0;
    commit_target_PC = '0; commit_btb_wr_en = 1'b0; commit_btb_PC = '0;
    commit_btb_target = '0; read_from_ras = 1'b0; jal_ret_addr = '0; if_inst = NOP;
  endtask

  // One clock: inputs already driven at the falling edge.
  task automatic cyc();
    int op, rd, rs1, idx, imm;
    bit jal, jalr, br, call, ret, accept, hit, exp_push, exp_pop;
    logic [31:0] npc;
    #1;
    op  = int'(if_inst & 32'h7f);
    rd  = int'((if_inst >> 7) & 32'h1f);
    rs1 = int'((if_inst >> 15) & 32'h1f);
    jal  = (op == 'h6f);
    jalr = (op == 'h67);
    br   = (op == 'h63);
    call = (jal || jalr) && link(rd);
    ret  = jalr && rd == 0 && link(rs1);
    imm  = int'(((if_inst >> 31) & 1) << 20) + int'(((if_inst >> 12) & 255) << 12)
         + int'(((if_inst >> 20) & 1) << 11) + int'(((if_inst >> 21) & 1023) << 1);
    if (imm >= (1 << 20)) imm -= (1 << 21);
    idx = int'((m_pc >> 2) % 8);
    hit = BTB_ON && m_bv[idx] && ((m_bpc[idx] >> 5) == (m_pc >> 5));
    if (ret && read_from_ras)  npc = jal_ret_addr;
    else if (jal)              npc = m_pc + 32'(imm);
    else if ((jalr || br) && hit) npc = m_btg[idx];
    else                       npc = m_pc + 4;
    accept   = if_inst_valid && !dispatch_stall && !commit_mis_pred && !m_flush;
    exp_push = accept && call;
    exp_pop  = accept && ret && read_from_ras;
    last_push = ras_push_enable;
    last_pl4  = jal_PC_plus_4;
    chk("ras_push", {31'd0, ras_push_enable}, {31'd0, exp_push});
    chk("ras_pop", {31'd0, ras_pop_enable}, {31'd0, exp_pop});
    chk("jal_pc_plus_4", jal_PC_plus_4, exp_push ? m_pc + 4 : 32'd0);
    @(posedge clock);
    #1;
    if (commit_mis_pred) begin
      m_pc = commit_target_PC; m_flush = 1'b1; m_valid = 1'b0;
    end else begin
      m_flush = 1'b0; m_valid = accept;
      if (accept) begin
        m_ppc = m_pc; m_pinst = if_inst; m_npc = npc; m_taken = (npc != m_pc + 4); m_pc = npc;
      end
    end
    if (commit_btb_wr_en) begin
      idx = int'((commit_btb_PC >> 2) % 8);
      m_bv[idx] = 1'b1; m_bpc[idx] = commit_btb_PC; m_btg[idx] = commit_btb_target;
    end
    chk("fetch_pc", fetch_PC, m_pc);
    chk("pkt_valid", {31'd0, if_packet_valid}, {31'd0, m_valid});
    if (m_valid) begin
      chk("pkt_pc", if_packet_PC, m_ppc);
      chk("pkt_inst", if_packet_inst, m_pinst);
      chk("pkt_npc", if_packet_NPC, m_npc);
      chk("pkt_taken", {31'd0, if_packet_pred_taken}, {31'd0, m_taken});
    end
    @(negedge clock);
  endtask

  task automatic redirect(input logic [31:0] tgt);
    idle(); commit_mis_pred = 1'b1; commit_target_PC = tgt; cyc();
    idle(); cyc();
  endtask

  initial begin
    idle();
    reset = 1'b1;
    m_pc = '0; m_flush = 1'b0; m_valid = 1'b0; m_taken = 1'b0;
    m_ppc = '0; m_pinst = '0; m_npc = '0;
    for (int i = 0; i < 8; i++) begin m_bv[i] = 1'b0; m_bpc[i] = '0; m_btg[i] = '0; end
    repeat (2) @(negedge clock);
    chk("rst_fetch_pc", fetch_PC, 32'h0);
    chk("rst_valid", {31'd0, if_packet_valid}, 32'd0);
    chk("rst_push_pop", {30'd0, ras_push_enable, ras_pop_enable}, 32'd0);
    chk("rst_pl4", jal_PC_plus_4, 32'd0);
    chk("rst_pkt", if_packet_PC | if_packet_inst | if_packet_NPC, 32'd0);
    reset = 1'b0;

    // nop at 0
    idle(); cyc();
    chk("nop_fetch_pc", fetch_PC, 32'h4);
    chk("nop_npc", if_packet_NPC, 32'h4);

    // call at 0x100
    redirect(32'h100);
    idle(); if_inst = CALL_J40; cyc();
    chk("call_push", {31'd0, last_push}, 32'd1);
    chk("call_pl4", last_pl4, 32'h104);
    chk("call_npc", if_packet_NPC, 32'h140);
    chk("call_taken", {31'd0, if_packet_pred_taken}, 32'd1);

    // ret with and without RAS content
    idle(); if_inst = RET; read_from_ras = 1'b1; jal_ret_addr = 32'h104; cyc();
    chk("ret_npc", if_packet_NPC, 32'h104);
    redirect(32'h140);
    idle(); if_inst = RET; read_from_ras = 1'b0; jal_ret_addr = 32'h104; cyc();
    chk("ret_empty_npc", if_packet_NPC, 32'h144);

    // call colliding with a redirect
    redirect(32'h200);
    idle(); if_inst = CALL_J40; commit_mis_pred = 1'b1; commit_target_PC = 32'h800; cyc();
    chk("mp_no_push", {31'd0, last_push}, 32'd0);
    idle(); cyc();
    chk("flush_valid", {31'd0, if_packet_valid}, 32'd0);
    idle(); cyc();
    chk("post_flush_pc", if_packet_PC, 32'h800);

    // stall holds a call
    redirect(32'h300);
    for (int i = 0; i < 3; i++) begin
      idle(); if_inst = CALL_J40; dispatch_stall = 1'b1; cyc();
      chk("stall_pc", fetch_PC, 32'h300);
    end
    idle(); if_inst = CALL_J40; cyc();
    chk("stall_release_push", {31'd0, last_push}, 32'd1);

    // BTB write then indirect jump lookup
    idle(); commit_mis_pred = 1'b1; commit_target_PC = 32'h400;
    commit_btb_wr_en = 1'b1; commit_btb_PC = 32'h400; commit_btb_target = 32'h900; cyc();
    idle(); cyc();
    idle(); if_inst = JALR_X6; cyc();
    chk("btb_npc", if_packet_NPC, BTB_ON ? 32'h900 : 32'h404);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      int kind;
      idle();
      kind = int'($urandom_range(0, 6));
      case (kind)
        0: if_inst = NOP;
        1: if_inst = ($urandom & 32'hFFFFF000) | ((($urandom % 2) ? 32'd1 : 32'd5) << 7) | 32'h6f;
        2: if_inst = ($urandom & 32'hFFFFF000) | (32'($urandom_range(6, 31)) << 7) | 32'h6f;
        3: if_inst = RET | (($urandom % 2) ? 32'h0 : 32'h00020000);
        4: if_inst = ($urandom & 32'hFFF00000) | (32'($urandom_range(0, 31)) << 15)
                     | ((($urandom % 2) ? 32'd1 : 32'd5) << 7) | 32'h67;
        5: if_inst = ($urandom & 32'hFFF00000) | (32'd6 << 15) | 32'h67;
        default: if_inst = ($urandom & 32'hFFFFF000) | 32'h63;
      endcase
      if_inst_valid  = ($urandom % 8) != 0;
      dispatch_stall = ($urandom % 5) == 0;
      read_from_ras  = $urandom % 2;
      jal_ret_addr   = $urandom & 32'hFFFFFFFC;
      if (($urandom % 12) == 0) begin
        commit_mis_pred = 1'b1; commit_target_PC = $urandom & 32'h0000FFFC;
      end
      if (($urandom % 3) == 0) begin
        commit_btb_wr_en  = 1'b1;
        commit_btb_PC     = ($urandom % 2) ? m_pc : ($urandom & 32'h0000FFFC);
        commit_btb_target = $urandom & 32'hFFFFFFFC;
      end
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fetch_next_pc.md
Name: fetch_next_pc

Overview:
- Fetch-stage PC generator directly upstream of the return address stack.
- Owns the fetch PC register and predecodes each fetched instruction:
  - drives RAS push/pop for calls and returns;
  - consumes the RAS top-of-stack to predict return targets;
  - selects the next PC from commit redirect, RAS, BTB, direct-jump target and PC+4.
- Emits a fetch packet (PC, instruction, predicted NPC) to the dispatch stage under a valid/stall handshake.

Parameters:
- XLEN, 32, address/data width (codebase macro value).
- RESET_PC, 32'h0, first fetch address after reset.
- BTB_ENTRIES, 8, direct-mapped BTB depth, power of 2.
- BTB_IDX_LEN, 3, log2(BTB_ENTRIES).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- if_inst  in  32  instruction word from icache for fetch_PC.
- if_inst_valid  in  1  if_inst is valid this cycle.
- dispatch_stall  in  1  dispatch cannot accept a packet this cycle.
- commit_mis_pred  in  1  commit detected a misprediction; redirect fetch.
- commit_target_PC  in  XLEN  correct PC on misprediction.
- commit_btb_wr_en  in  1  commit writes a resolved taken jalr/branch into the BTB.
- commit_btb_PC  in  XLEN  PC of the resolved instruction.
- commit_btb_target  in  XLEN  its resolved target.
- read_from_ras  in  1  RAS non-empty.
- jal_ret_addr  in  XLEN  RAS top of stack.
- fetch_PC  out  XLEN  PC presented to icache.
- if_packet_valid  out  1  packet valid to dispatch.
- if_packet_PC  out  XLEN  PC of the packet.
- if_packet_inst  out  32  instruction of the packet.
- if_packet_NPC  out  XLEN  predicted next PC.
- if_packet_pred_taken  out  1  prediction is not PC+4.
- ras_push_enable  out  1  push to RAS this cycle.
- ras_pop_enable  out  1  pop from RAS this cycle.
- jal_PC_plus_4  out  XLEN  value to push (fetch_PC+4).

Behaviour:
- Reset (async, active-high):
  - fetch_PC=RESET_PC, state=RUN.
  - All BTB valid bits cleared.
  - All outputs 0, except fetch_PC as above.
- Accept condition: accept = if_inst_valid & ~dispatch_stall & ~commit_mis_pred & state==RUN.
- Predecode (combinational on if_inst; link register = x1 or x5):
  - CALL_J: opcode 1101111 with rd = link.
  - JAL_PLAIN: opcode 1101111 with any other rd.
  - RET: opcode 1100111, rd=x0, rs1 = link.
  - CALL_R: opcode 1100111, rd = link.
  - JALR_OTHER: any other jalr.
  - BR: opcode 1100011.
- NPC priority when accepted:
  1. RET & read_from_ras -> jal_ret_addr.
  2. CALL_J / JAL_PLAIN -> fetch_PC + sign-extended J-immediate (XLEN wrap, no overflow flag).
  3. CALL_R / JALR_OTHER / BR with BTB hit -> BTB target.
  4. Otherwise fetch_PC+4.
  - if_packet_pred_taken = (NPC != fetch_PC+4).
- RAS control:
  - ras_push_enable = accept & (CALL_J | CALL_R); jal_PC_plus_4 = fetch_PC+4.
  - ras_pop_enable = accept & RET & read_from_ras. A RET with an empty RAS is never popped; its NPC falls through to rule 3/4.
  - Push and pop are never both asserted. A call whose rs1 is also a link register is push only.
  - All RAS controls are combinational, same cycle as accept.
- Packet register: on accept, PC/inst/NPC/pred_taken are latched and if_packet_valid=1 next cycle, and fetch_PC<=NPC. Otherwise if_packet_valid=0 next cycle and fetch_PC holds.
- dispatch_stall: fetch_PC is held and no push/pop occurs; the icache re-presents the instruction.
- State machine:
  - RUN: normal fetch.
  - commit_mis_pred in any state -> fetch_PC<=commit_target_PC, if_packet_valid<=0, no push/pop that cycle, go to FLUSH.
  - FLUSH: one bubble cycle; no accept, if_packet_valid=0; then RUN.
  - commit_mis_pred while in FLUSH -> new target taken, stay in FLUSH one more cycle.
- BTB:
  - Indexed by PC[BTB_IDX_LEN+1:2]; tag = remaining upper bits.
  - Commit write occurs on the next edge and overwrites the slot unconditionally.
  - A write and a lookup to the same index in the same cycle return the old contents (no bypass).
  - commit_mis_pred does not clear the BTB.

Optional Feature:
- Macro FETCH_BTB_EN.
- Defined: BTB present as above.
- Undefined:
  - No BTB storage.
  - commit_btb_* ports remain but are ignored.
  - CALL_R/JALR_OTHER predict fetch_PC+4; branches predict not-taken.

Decomposition:
- Shared package (fetch_pkg): opcode constants (OPC_JAL, OPC_JALR, OPC_BRANCH), link-register numbers, predecode-class enum, fetch-state enum (RUN, FLUSH), IF packet struct.
- Sub-module fetch_btb: direct-mapped tag/target/valid arrays, async reset of valid bits, combinational lookup port, one commit write port. Instantiated only under FETCH_BTB_EN.

Test Plan:
- Reset released, if_inst_valid=1, nop 0x00000013 at PC 0x0 -> fetch_PC=0x4 next cycle, packet PC=0x0 NPC=0x4 valid=1, no push/pop.
- jal x1,+0x40 (0x040000EF) at 0x100 -> ras_push_enable=1 and jal_PC_plus_4=0x104 that cycle; NPC=0x140, pred_taken=1.
- ret (0x00008067) at 0x140 with read_from_ras=1, jal_ret_addr=0x104 -> ras_pop_enable=1, NPC=0x104. Same with read_from_ras=0 -> no pop, NPC=0x144.
- jal x1 at 0x200 in the same cycle as commit_mis_pred=1, target 0x800 -> no push, packet valid=0 for 2 cycles (the redirect cycle plus FLUSH), then fetch at 0x800.
- dispatch_stall=1 for 3 cycles with jal x1 at 0x300 -> fetch_PC stays 0x300 and no push; exactly one push on the release cycle.
- FETCH_BTB_EN defined: commit writes PC 0x400 -> 0x900, then jalr x0,0(x6) fetched at 0x400 -> NPC=0x900. Without the macro -> NPC=0x404.
